// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Tracks the fetch address through boot, run and halt, applies trap and
// branch redirects with trap taking priority, diverts misaligned branch
// targets to the trap vector, and counts accepted fetches.
module pc_gen #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned          STEP         = 4,
    parameter int unsigned          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             fetch_ready_i,
    output logic             fetch_valid_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus_o,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             trap_valid_i,
    input  logic [XLEN-1:0]  trap_vector_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic             halted_o,
    output logic             misalign_o,
    output logic [XLEN-1:0]  badaddr_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    // Only 2-byte and 4-byte instruction granules exist, so the alignment
    // mask covers one or two low address bits.
    localparam logic [XLEN-1:0]  ALIGN_MASK = (STEP == 2) ? XLEN'(1) : XLEN'(3);
    localparam logic [XLEN-1:0]  STEP_INC   = XLEN'(STEP);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  badaddr_q, badaddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             misaligned_s;
    logic             active_s;
    logic             accept_s;

    assign misaligned_s = (redirect_pc_i & ALIGN_MASK) != {XLEN{1'b0}};
    // Redirects and traps are honoured in RUN and HALT, never during BOOT.
    assign active_s     = (state_q == ST_RUN) || (state_q == ST_HALT);
    assign accept_s     = (state_q == ST_RUN) && fetch_ready_i && !stall_i
                          && !trap_valid_i && !redirect_valid_i;

    // Next-state, next-PC, misalign capture and counter update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        badaddr_d  = badaddr_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt_i) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (active_s && trap_valid_i) begin
            pc_d = trap_vector_i & ~ALIGN_MASK;
        end else if (active_s && redirect_valid_i && misaligned_s) begin
            pc_d       = trap_vector_i & ~ALIGN_MASK;
            misalign_d = 1'b1;
            badaddr_d  = redirect_pc_i;
        end else if (active_s && redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (accept_s) begin
            pc_d = pc_q + STEP_INC;
        end else begin
            pc_d = pc_q;
        end

        if (accept_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            badaddr_q  <= {XLEN{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            badaddr_q  <= badaddr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fetch_valid_o = (state_q == ST_RUN);
    assign halted_o      = (state_q == ST_HALT);
    assign pc_o          = pc_q;
    assign pc_plus_o     = pc_q + STEP_INC;
    assign misalign_o    = misalign_q;
    assign badaddr_o     = badaddr_q;
    assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen. Three instances share stimulus:
// u_dut (STEP=4, CNT_W=32), u_dut2 (STEP=2), u_dut3 (CNT_W=2).
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall_i, fetch_ready_i;
    logic        redirect_valid_i, trap_valid_i;
    logic [31:0] redirect_pc_i, trap_vector_i;
    logic        halt_i, resume_i;

    logic        fv, halted, mis;
    logic [31:0] pc, pcp, bad, cnt;
    logic        fv2, halted2, mis2;
    logic [31:0] pc2, pcp2, bad2, cnt2;
    logic        fv3, halted3, mis3;
    logic [31:0] pc3, pcp3, bad3;
    logic [1:0]  cnt3;

    int n_vec = 0;
    int n_err = 0;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .STEP(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .fetch_valid_o(fv), .pc_o(pc), .pc_plus_o(pcp),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
        .halt_i(halt_i), .resume_i(resume_i), .halted_o(halted),
        .misalign_o(mis), .badaddr_o(bad), .fetch_count_o(cnt));

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .STEP(2), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .fetch_valid_o(fv2), .pc_o(pc2), .pc_plus_o(pcp2),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
        .halt_i(halt_i), .resume_i(resume_i), .halted_o(halted2),
        .misalign_o(mis2), .badaddr_o(bad2), .fetch_count_o(cnt2));

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .STEP(4), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .fetch_valid_o(fv3), .pc_o(pc3), .pc_plus_o(pcp3),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
        .halt_i(halt_i), .resume_i(resume_i), .halted_o(halted3),
        .misalign_o(mis3), .badaddr_o(bad3), .fetch_count_o(cnt3));

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        stall_i = 1'b0; fetch_ready_i = 1'b1;
        redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
        trap_valid_i = 1'b0; trap_vector_i = 32'h0;
        halt_i = 1'b0; resume_i = 1'b0;

        // Reset state
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", {31'b0, fv}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_mis", {31'b0, mis}, 32'h0);
        chk("rst_bad", bad, 32'h0);
        chk("rst_cnt", cnt, 32'h0);

        // Release reset between edges; one BOOT cycle follows
        @(posedge clk);
        #2 rst = 1'b1;
        chk("boot_fv", {31'b0, fv}, 32'h0);
        tick();
        chk("run_fv", {31'b0, fv}, 32'h1);
        chk("run_pc0", pc, 32'h0);
        chk("run_cnt0", cnt, 32'h0);
        chk("pcplus0", pcp, 32'h4);

        // Sequential fetches: STEP=4 and STEP=2 instances, 2-bit counter wraps 3->0
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", pc, 32'(4 * i));
            chk("seq_cnt", cnt, 32'(i));
            chk("seq_pc_step2", pc2, 32'(2 * i));
            chk("seq_cnt_w2", {30'b0, cnt3}, 32'(i % 4));
        end

        // Not ready: hold
        fetch_ready_i = 1'b0;
        repeat (3) begin
            tick();
            chk("nrdy_pc", pc, 32'h10);
            chk("nrdy_cnt", cnt, 32'h4);
            chk("nrdy_fv", {31'b0, fv}, 32'h1);
        end

        // Stall with ready: hold
        fetch_ready_i = 1'b1; stall_i = 1'b1;
        repeat (2) begin
            tick();
            chk("stall_pc", pc, 32'h10);
            chk("stall_cnt", cnt, 32'h4);
        end

        // Trap beats redirect, applied despite stall
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
        trap_valid_i = 1'b1; trap_vector_i = 32'h80;
        tick();
        chk("trap_pc", pc, 32'h80);
        chk("trap_cnt", cnt, 32'h4);
        chk("trap_mis", {31'b0, mis}, 32'h0);
        trap_valid_i = 1'b0; stall_i = 1'b0;

        // Misaligned redirect: STEP=4 diverts to trap vector, STEP=2 takes it
        redirect_pc_i = 32'h102; trap_vector_i = 32'h40;
        tick();
        chk("mis_pc", pc, 32'h40);
        chk("mis_pulse", {31'b0, mis}, 32'h1);
        chk("mis_bad", bad, 32'h102);
        chk("mis_cnt", cnt, 32'h4);
        chk("step2_pc", pc2, 32'h102);
        chk("step2_mis", {31'b0, mis2}, 32'h0);
        redirect_valid_i = 1'b0;
        tick();
        chk("mis_end", {31'b0, mis}, 32'h0);
        chk("bad_hold", bad, 32'h102);
        chk("after_mis_pc", pc, 32'h44);
        chk("after_mis_cnt", cnt, 32'h5);

        // Halt at 0x20: same-cycle advance to 0x24, then halted
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h20;
        tick();
        chk("redir_pc", pc, 32'h20);
        redirect_valid_i = 1'b0; halt_i = 1'b1;
        tick();
        chk("halt_pc", pc, 32'h24);
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_fv", {31'b0, fv}, 32'h0);
        chk("halt_cnt", cnt, 32'h6);
        halt_i = 1'b0;
        tick();
        chk("halt_hold_pc", pc, 32'h24);
        chk("halt_hold_flag", {31'b0, halted}, 32'h1);

        // Redirect while halted
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h300;
        tick();
        chk("hredir_pc", pc, 32'h300);
        chk("hredir_halted", {31'b0, halted}, 32'h1);
        redirect_valid_i = 1'b0; resume_i = 1'b1;
        tick();
        chk("resume_halted", {31'b0, halted}, 32'h0);
        chk("resume_fv", {31'b0, fv}, 32'h1);
        chk("resume_pc", pc, 32'h300);
        resume_i = 1'b0;
        tick();
        chk("resume_adv", pc, 32'h304);
        chk("resume_cnt", cnt, 32'h7);

        // Halt and resume together: halt wins in RUN, resume wins in HALT
        halt_i = 1'b1; resume_i = 1'b1;
        tick();
        chk("both_run", {31'b0, halted}, 32'h1);
        chk("both_run_pc", pc, 32'h308);
        tick();
        chk("both_halt", {31'b0, halted}, 32'h0);
        chk("both_halt_pc", pc, 32'h308);
        halt_i = 1'b0; resume_i = 1'b0;
        tick();
        chk("both_adv", pc, 32'h30C);
        chk("both_cnt", cnt, 32'h9);

        // Address wrap modulo 2^32
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        chk("wrap_plus", pcp, 32'h0);
        redirect_valid_i = 1'b0;
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_cnt", cnt, 32'hA);

        // Asynchronous reset mid-cycle
        #3 rst = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_cnt", cnt, 32'h0);
        chk("arst_fv", {31'b0, fv}, 32'h0);
        chk("arst_bad", bad, 32'h0);

        // Trap ignored during BOOT
        @(posedge clk);
        #2 rst = 1'b1;
        trap_valid_i = 1'b1; trap_vector_i = 32'h80;
        tick();
        chk("boot_trap_pc", pc, 32'h0);
        chk("boot_trap_fv", {31'b0, fv}, 32'h1);
        trap_valid_i = 1'b0;
        tick();
        chk("post_boot_pc", pc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator. Successor to the single-register PC stage; sits between the branch/trap logic and the instruction-memory fetch port.
- Adds stall, a fetch valid/ready handshake, prioritised redirect and trap, misaligned-target detection, halt/resume, and an accepted-fetch counter.
- Drives the fetch address and pc+step to decode.

Parameters:
XLEN, 32, address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits)
STEP, 4, byte increment per sequential fetch (2 or 4 only)
CNT_W, 32, width of accepted-fetch counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
stall_i  input  1  pipeline stall; blocks sequential advance
fetch_ready_i  input  1  imem accepts current fetch this cycle
fetch_valid_o  output  1  fetch request valid
pc_o  output  XLEN  current fetch address (registered)
pc_plus_o  output  XLEN  pc_o + STEP (combinational)
redirect_valid_i  input  1  branch/jump taken
redirect_pc_i  input  XLEN  branch/jump target
trap_valid_i  input  1  exception/interrupt taken
trap_vector_i  input  XLEN  trap handler address
halt_i  input  1  request halt
resume_i  input  1  leave halt
halted_o  output  1  state == HALT
misalign_o  output  1  one-cycle pulse: misaligned redirect trapped
badaddr_o  output  XLEN  last misaligned redirect target (held)
fetch_count_o  output  CNT_W  accepted-fetch count

Behaviour:
- Reset (rst=0, async, immediate, including mid-operation): pc_o=RESET_VECTOR, state=BOOT, fetch_valid_o=0, halted_o=0, misalign_o=0, badaddr_o=0, fetch_count_o=0.
- ALIGN mask: low 1 bit when STEP=2, low 2 bits when STEP=4. misaligned = (redirect_pc_i & mask) != 0.
- States:
  - BOOT: fetch_valid_o=0. Exactly one cycle after rst rises, then RUN unconditionally. Trap/redirect inputs are ignored in BOOT.
  - RUN: fetch_valid_o=1.
  - HALT: fetch_valid_o=0, halted_o=1.
- Next-PC priority, evaluated in RUN and HALT:
  1. trap_valid_i: pc <= trap_vector_i & ~mask.
  2. redirect_valid_i && misaligned: pc <= trap_vector_i & ~mask; misalign_o=1 next cycle; badaddr_o <= redirect_pc_i.
  3. redirect_valid_i: pc <= redirect_pc_i.
  4. In RUN, fetch_valid_o && fetch_ready_i && !stall_i: pc <= pc_o + STEP.
  5. Otherwise pc holds.
- Trap and redirect are applied regardless of stall_i and fetch_ready_i. The in-flight request is abandoned and imem must tolerate the address change.
- Otherwise pc_o is stable while fetch_valid_o=1 and fetch_ready_i=0.
- Addition wraps modulo 2^XLEN; no overflow flag.
- Accepted fetch = state RUN && fetch_ready_i && !stall_i && !trap_valid_i && !redirect_valid_i.
  - fetch_count_o increments by 1 per accepted fetch and wraps to 0 at 2^CNT_W.
- Halt/resume:
  - halt_i in RUN: the same-cycle PC update (per priority) still occurs; state=HALT next cycle.
  - resume_i in HALT: state=RUN next cycle.
  - halt_i and resume_i together: halt wins in RUN; resume wins in HALT.
  - Trap or redirect in HALT updates pc; state remains HALT.
- misalign_o is high for exactly one cycle per misaligned redirect.
- badaddr_o holds its value until the next misaligned redirect or reset.
- pc_plus_o is purely combinational from pc_o and is valid in every state.

Test Plan:
- Reset release, RESET_VECTOR=0, fetch_ready_i=1 -> fetch_valid_o=0 for 1 cycle; then pc_o=0,4,8,C on consecutive cycles; fetch_count_o=1,2,3.
- fetch_ready_i=0 for 3 cycles at pc_o=0x10 -> pc_o holds 0x10 and fetch_count_o holds. Same hold with stall_i=1 and ready=1.
- redirect 0x200 and trap vector 0x80 asserted in the same cycle with stall_i=1 -> pc_o=0x80 next cycle; fetch_count_o unchanged.
- redirect_pc_i=0x102, STEP=4, trap_vector_i=0x40 -> pc_o=0x40, misalign_o pulses 1 cycle, badaddr_o=0x102. With STEP=2, 0x102 is taken normally.
- halt_i at pc_o=0x20 with ready=1 -> pc_o=0x24, then halted_o=1, fetch_valid_o=0, pc_o stays 0x24. Redirect to 0x300 while halted -> pc_o=0x300, halted_o stays 1. resume_i -> fetching resumes at 0x300.
- rst=0 asserted mid-fetch, async between edges -> outputs reset immediately. pc_o=0xFFFF_FFFC advancing -> wraps to 0x0. CNT_W=2 -> count goes 3 -> 0.
